aes_cipher_ctrl: RTL and testbench

//  Sequencer for the iterative AES encryption round datapath (cipher).
//  - Accepts one 128-bit block and a key-size code over a valid/ready handshake.
//  - Drives the cipher's sync pulse and round count NR.
//  - Waits the exact number of round cycles, registers the result.
//  - Presents the result over a valid/ready handshake with backpressure.

---
 rtl/aes_cipher_ctrl.sv | 85 ++++++++
 tb/tb_aes_cipher_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_ctrl.sv
// aes_cipher_ctrl: load/run/capture sequencer for an iterative AES cipher round datapath.
// Optional `AES_CTRL_ABORT_EN adds i_abort, which returns any busy state to IDLE on the next edge.
module aes_cipher_ctrl #(
  parameter int DW   = 128,
  parameter int NR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_key_size,
  input  logic [DW-1:0]   i_data,
  output logic            o_sync,
  output logic [NR_W-1:0] o_nr,
  output logic [DW-1:0]   o_cipher_data,
  input  logic [DW-1:0]   i_cipher_result,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_busy,
`ifdef AES_CTRL_ABORT_EN
  input  logic            i_abort,
`endif
  output logic            o_cfg_err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_DONE} state_t;
  state_t          r_state, w_next;
  logic [NR_W-1:0] r_cnt, r_nr, w_nr_dec;
  logic [DW-1:0]   r_cipher_data, r_data;
  logic            r_cfg_err;
  logic            w_accept, w_legal, w_abort, w_last;
  assign w_accept = i_valid && (r_state == S_IDLE);
  assign w_legal  = i_key_size != 2'b11;
  assign w_nr_dec = (i_key_size == 2'b00) ? NR_W'(10) : (i_key_size == 2'b01) ? NR_W'(12) : NR_W'(14);
  assign w_last   = r_cnt == r_nr - NR_W'(2);
`ifdef AES_CTRL_ABORT_EN
  assign w_abort  = i_abort && (r_state != S_IDLE);
`else
  assign w_abort  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = S_IDLE;
    else case (r_state)
      S_IDLE:  w_next = (w_accept && w_legal) ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   w_next = w_last ? S_CAPT : S_RUN;
      S_CAPT:  w_next = S_DONE;
      S_DONE:  w_next = i_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_ready = r_state == S_IDLE;
    o_busy  = r_state != S_IDLE;
    o_sync  = r_state == S_LOAD;
    o_valid = r_state == S_DONE;
  end
  // Round counter only advances in RUN; every other state (and abort) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_nr          <= NR_W'(10);
      r_cipher_data <= '0;
      r_data        <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cnt     <= (r_state == S_RUN && !w_abort) ? r_cnt + NR_W'(1) : '0;
      r_cfg_err <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_cipher_data <= i_data;
        r_nr          <= w_nr_dec;
      end
      if (r_state == S_CAPT && !w_abort) r_data <= i_cipher_result;
    end
  end
  assign o_nr          = r_nr;
  assign o_cipher_data = r_cipher_data;
  assign o_data        = r_data;
  assign o_cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// tb_aes_cipher_ctrl: scoreboard bench with a behavioural round-counting cipher stand-in.
module tb_aes_cipher_ctrl;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic clk, rst_n, i_valid, o_ready, o_sync, o_valid, i_ready, o_busy, o_cfg_err;
  logic [1:0] i_key_size;
  logic [127:0] i_data, o_cipher_data, i_cipher_result, o_data;
  logic [3:0] o_nr;
`ifdef AES_CTRL_ABORT_EN
  logic i_abort = 1'b0;
`endif
  aes_cipher_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_key_size(i_key_size),
    .i_data(i_data), .o_sync(o_sync), .o_nr(o_nr), .o_cipher_data(o_cipher_data),
    .i_cipher_result(i_cipher_result), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_busy(o_busy),
`ifdef AES_CTRL_ABORT_EN
    .i_abort(i_abort),
`endif
    .o_cfg_err(o_cfg_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nr_of(logic [1:0] ks);
    return 10 + 2 * int'(ks);
  endfunction
  function automatic logic [127:0] golden(logic [127:0] d, int nr);
    if (d == PT) return (nr == 10) ? C128 : (nr == 12) ? C192 : C256;
    return {d[63:0], d[127:64]} ^ {32{4'(nr)}};
  endfunction

  // Cipher stand-in: loads on sync, one round per edge, result only correct after NR-1 rounds.
  logic [127:0] st = '0;
  int rc = 99;
  always @(posedge clk) begin
    if (o_sync) begin
      st <= o_cipher_data;
      rc <= 0;
    end else if (rc < 50) rc <= rc + 1;
  end
  assign i_cipher_result = (rc == int'(o_nr) - 1) ? golden(st, int'(o_nr)) : ~st;

  typedef struct {logic [127:0] pt; logic [127:0] ct; int nr; int acc;} exp_t;
  exp_t q[$];
  int cfg_q[$];

  bit rdy_rand = 0;
  always @(negedge clk) if (rdy_rand) i_ready = 1'($urandom_range(0, 1));

  initial begin : monitor
    logic pv;
    logic [127:0] pd;
    exp_t e;
    pv = 0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy_vs_ready", o_busy, !o_ready);
        if (o_sync) begin
          if (q.size() == 0) chk("sync_unexpected", 1, 0);
          else begin
            chk("sync_cycle", cyc, q[0].acc);
            chk("sync_nr", o_nr, q[0].nr);
            chk("sync_cipher_data", o_cipher_data, q[0].pt);
          end
        end
        if (o_valid && !pv) begin
          if (q.size() == 0) chk("valid_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("result_data", o_data, e.ct);
            chk("latency", cyc - e.acc, e.nr + 1);
          end
        end else if (o_valid && pv) chk("hold_data", o_data, pd);
        if (o_cfg_err) begin
          if (cfg_q.size() == 0) chk("cfg_err_unexpected", 1, 0);
          else begin
            chk("cfg_err_cycle", cyc, cfg_q.pop_front());
            chk("cfg_err_busy", o_busy, 0);
          end
        end
      end
      pv = o_valid;
      pd = o_data;
    end
  end

  task automatic send(logic [127:0] d, logic [1:0] ks, output int acc);
    int t = 0;
    i_valid = 1'b1;
    i_data = d;
    i_key_size = ks;
    while (!o_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    acc = cyc + 1;
    if (!o_ready) chk("send_timeout", 0, 1);
    else if (ks == 2'b11) cfg_q.push_back(cyc + 1);
    else q.push_back('{d, golden(d, nr_of(ks)), nr_of(ks), cyc + 1});
    @(negedge clk);
  endtask
  task automatic idle();
    i_valid = 1'b0;
    i_data = {4{$urandom}};
    i_key_size = 2'($urandom);
  endtask
  task automatic wait_sig(string nm, bit want_valid);
    int t = 0;
    while ((want_valid ? !o_valid : !o_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk(nm, 0, 1);
  endtask
  task automatic chk_reset();
    chk("rst_valid", o_valid, 0);
    chk("rst_sync", o_sync, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cfg_err", o_cfg_err, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_nr", o_nr, 10);
    chk("rst_data", o_data, 0);
    chk("rst_cipher_data", o_cipher_data, 0);
  endtask

  initial begin : main
    int a1, a2, t;
    logic [127:0] hold;
    rst_n = 1'b0;
    i_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      send(PT, 2'(k), a1);
      idle();
      wait_sig("fips_done", 0);
    end
    i_ready = 1'b0;
    send({4{$urandom}}, 2'b01, a1);
    idle();
    wait_sig("bp_valid_timeout", 1);
    repeat (5) begin
      chk("bp_ready", o_ready, 0);
      chk("bp_busy", o_busy, 1);
      chk("bp_valid", o_valid, 1);
      @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", o_valid, 0);
    chk("bp_release_ready", o_ready, 1);
    send({4{$urandom}}, 2'b11, a1);
    idle();
    chk("cfg_pulse", o_cfg_err, 1);
    chk("cfg_no_sync", o_sync, 0);
    chk("cfg_idle", o_busy, 0);
    @(negedge clk);
    chk("cfg_pulse_end", o_cfg_err, 0);
    chk("cfg_ready", o_ready, 1);
    send({4{$urandom}}, 2'b00, a1);
    send({4{$urandom}}, 2'b00, a2);
    idle();
    chk("b2b_spacing", a2 - a1, 13);
    wait_sig("b2b_done", 0);
    send({4{$urandom}}, 2'b00, a1);
    idle();
    while (cyc < a1 + 5) @(negedge clk);
    chk("mid_run_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(PT, 2'b10, a1);
    idle();
    wait_sig("post_rst_done", 0);
`ifdef AES_CTRL_ABORT_EN
    hold = o_data;
    send({4{$urandom}}, 2'b00, a1);
    idle();
    while (cyc < a1 + 3) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    q.delete();
    chk("abort_ready", o_ready, 1);
    chk("abort_valid", o_valid, 0);
    chk("abort_data_kept", o_data, hold);
`endif
    rdy_rand = 1;
    for (int n = 0; n < 40; n++) begin
      send({4{$urandom}}, 2'($urandom_range(0, 3)), a1);
      idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    t = 0;
    while ((q.size() > 0 || !o_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    rdy_rand = 0;
    i_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("drain_blocks", q.size(), 0);
    chk("drain_cfg", cfg_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
